// File: rtl/pak_fir_pkg.sv
// Shared constants and types for the pak_fir_tdm multi-channel FIR filter:
// register map, control/status bit positions and the sequencer states.
package pak_fir_pkg;

   localparam logic [5:0] ADDR_CTRL       = 6'h00;
   localparam logic [5:0] ADDR_STATUS     = 6'h01;
   localparam logic [5:0] ADDR_COEFF_BASE = 6'h20;

   localparam int CTRL_EN_BIT    = 0;
   localparam int CTRL_CLR_BIT   = 1;
   localparam int CTRL_SAT_BIT   = 2;

   localparam int STAT_BUSY_BIT  = 0;
   localparam int STAT_OVF_BIT   = 1;
   localparam int STAT_WRERR_BIT = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MAC  = 2'd1,
      ST_OUT  = 2'd2
   } state_e;

endpackage

// File: rtl/pak_fir_round_sat.sv
// Rounds the accumulator half toward +inf, drops FRAC_W fraction bits and
// either clamps or wraps into DATA_WIDTH; o_ovf flags an out-of-range result.
module pak_fir_round_sat #(
   parameter int ACC_W      = 41,
   parameter int DATA_WIDTH = 16,
   parameter int FRAC_W     = 14
) (
   input  logic signed [ACC_W-1:0]      i_acc,
   input  logic                         i_sat_en,
   output logic signed [DATA_WIDTH-1:0] o_data,
   output logic                         o_ovf
);

   localparam int SW = ACC_W + 1;
   localparam logic [SW-1:0] HALF = SW'(1) << (FRAC_W - 1);
   localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   logic signed [SW-1:0]         w_sum;
   logic signed [SW-1:0]         w_shr;
   logic [SW-DATA_WIDTH:0]       w_top;

   // One guard bit above the accumulator so the rounding add cannot wrap.
   assign w_sum = {i_acc[ACC_W-1], i_acc} + HALF;
   assign w_shr = w_sum >>> FRAC_W;
   assign w_top = w_shr[SW-1:DATA_WIDTH-1];
   assign o_ovf = (w_top != {(SW-DATA_WIDTH+1){w_shr[SW-1]}});

   always_comb begin
      if (o_ovf && i_sat_en) begin
         o_data = w_shr[SW-1] ? SAT_MIN : SAT_MAX;
      end else begin
         o_data = w_shr[DATA_WIDTH-1:0];
      end
   end

endmodule

// File: rtl/pak_fir_tdm.sv
// Time-multiplexed multi-channel FIR: one shared coefficient set, a delay line
// per channel, one MAC per cycle and a small register port with sticky status.
module pak_fir_tdm
   import pak_fir_pkg::*;
#(
   parameter int DATA_WIDTH  = 16,
   parameter int COEFF_WIDTH = 16,
   parameter int N_TAPS      = 8,
   parameter int N_CH        = 2,
   parameter int FRAC_W      = 14,
   parameter int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                  clk,
   input  logic                  arst_n,
   input  logic [5:0]            addr,
   input  logic                  write_en,
   input  logic [15:0]           wdata,
   output logic [15:0]           rdata,
   input  logic [DATA_WIDTH-1:0] src_data_in,
   input  logic [CH_W-1:0]       src_ch_in,
   input  logic                  src_valid_in,
   output logic                  src_ready_out,
   output logic [DATA_WIDTH-1:0] dst_data_out,
   output logic [CH_W-1:0]       dst_ch_out,
   output logic                  dst_valid_out,
   input  logic                  dst_ready_in
);

   localparam int PROD_W = DATA_WIDTH + COEFF_WIDTH;
   localparam int ACC_W  = PROD_W + $clog2(N_TAPS) + 1;
   localparam int KW     = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;

   state_e                        r_state;
   state_e                        w_state_nxt;
   logic                          r_en;
   logic                          r_sat_en;
   logic                          r_ovf;
   logic                          r_wr_err;
   logic signed [COEFF_WIDTH-1:0] r_coeff [N_TAPS];
   logic signed [DATA_WIDTH-1:0]  r_hist  [N_CH][N_TAPS];
   logic [CH_W-1:0]               r_ch;
   logic [KW-1:0]                 r_k;
   logic signed [ACC_W-1:0]       r_acc;
   logic signed [DATA_WIDTH-1:0]  r_dout;
   logic [CH_W-1:0]               r_dch;

   logic                          w_idle;
   logic                          w_accept;
   logic                          w_ch_bad;
   logic                          w_push;
   logic                          w_last;
   logic                          w_wr_ctrl;
   logic                          w_wr_stat;
   logic                          w_coeff_hit;
   logic                          w_wr_coeff;
   logic                          w_clr;
   logic                          w_ovf_set;
   logic                          w_err_set;
   logic [KW-1:0]                 w_coeff_idx;
   logic signed [DATA_WIDTH-1:0]  w_x;
   logic signed [COEFF_WIDTH-1:0] w_c;
   logic signed [PROD_W-1:0]      w_prod;
   logic signed [ACC_W-1:0]       w_acc_nxt;
   logic signed [DATA_WIDTH-1:0]  w_rs_data;
   logic                          w_rs_ovf;

   assign w_idle      = (r_state == ST_IDLE);
   assign w_accept    = w_idle && r_en && src_valid_in;
   assign w_ch_bad    = ({1'b0, src_ch_in} >= (CH_W+1)'(N_CH));
   assign w_push      = w_accept && !w_ch_bad;
   assign w_last      = (r_k == KW'(N_TAPS - 1));
   assign w_wr_ctrl   = write_en && (addr == ADDR_CTRL);
   assign w_wr_stat   = write_en && (addr == ADDR_STATUS);
   assign w_coeff_hit = addr[5] && ({27'd0, addr[4:0]} < 32'(N_TAPS));
   assign w_coeff_idx = addr[KW-1:0];
   assign w_wr_coeff  = write_en && w_coeff_hit;
   assign w_clr       = w_wr_ctrl && wdata[CTRL_CLR_BIT] && w_idle;

   assign w_x       = r_hist[r_ch][r_k];
   assign w_c       = r_coeff[r_k];
   assign w_prod    = PROD_W'(w_x) * PROD_W'(w_c);
   assign w_acc_nxt = r_acc + ACC_W'(w_prod);

   // The final tap's product is folded in combinationally so the output
   // register loads on the same edge as the last MAC.
   pak_fir_round_sat #(
      .ACC_W      (ACC_W),
      .DATA_WIDTH (DATA_WIDTH),
      .FRAC_W     (FRAC_W)
   ) u_round_sat (
      .i_acc    (w_acc_nxt),
      .i_sat_en (r_sat_en),
      .o_data   (w_rs_data),
      .o_ovf    (w_rs_ovf)
   );

   assign w_ovf_set = (r_state == ST_MAC) && w_last && w_rs_ovf;
   assign w_err_set = (w_accept && w_ch_bad) || (w_wr_coeff && !w_idle);

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: w_state_nxt = w_push ? ST_MAC : ST_IDLE;
         ST_MAC:  w_state_nxt = w_last ? ST_OUT : ST_MAC;
         ST_OUT:  w_state_nxt = dst_ready_in ? ST_IDLE : ST_OUT;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Delay lines: newest sample lands in tap 0; CLR_HIST zeroes every line.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         for (int c = 0; c < N_CH; c++) begin
            for (int k = 0; k < N_TAPS; k++) begin
               r_hist[c][k] <= '0;
            end
         end
      end else begin
         for (int c = 0; c < N_CH; c++) begin
            if (w_push && (src_ch_in == CH_W'(c))) begin
               r_hist[c][0] <= src_data_in;
               for (int k = 1; k < N_TAPS; k++) begin
                  r_hist[c][k] <= w_clr ? '0 : r_hist[c][k-1];
               end
            end else if (w_clr) begin
               for (int k = 0; k < N_TAPS; k++) begin
                  r_hist[c][k] <= '0;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_ch   <= '0;
         r_k    <= '0;
         r_acc  <= '0;
         r_dout <= '0;
         r_dch  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_push) begin
                  r_ch  <= src_ch_in;
                  r_k   <= '0;
                  r_acc <= '0;
               end
            end
            ST_MAC: begin
               r_acc <= w_acc_nxt;
               r_k   <= r_k + KW'(1);
               if (w_last) begin
                  r_dout <= w_rs_data;
                  r_dch  <= r_ch;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Control, sticky status (a new event beats a same-cycle W1C) and coefficients.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_en     <= 1'b0;
         r_sat_en <= 1'b0;
         r_ovf    <= 1'b0;
         r_wr_err <= 1'b0;
         for (int k = 0; k < N_TAPS; k++) begin
            r_coeff[k] <= '0;
         end
      end else begin
         if (w_wr_ctrl) begin
            r_en     <= wdata[CTRL_EN_BIT];
            r_sat_en <= wdata[CTRL_SAT_BIT];
         end
         r_ovf    <= w_ovf_set | (r_ovf & ~(w_wr_stat & wdata[STAT_OVF_BIT]));
         r_wr_err <= w_err_set | (r_wr_err & ~(w_wr_stat & wdata[STAT_WRERR_BIT]));
         if (w_wr_coeff && w_idle) begin
            r_coeff[w_coeff_idx] <= wdata[COEFF_WIDTH-1:0];
         end
      end
   end

   always_comb begin
      rdata = 16'd0;
      case (addr)
         ADDR_CTRL: begin
            rdata[CTRL_EN_BIT]  = r_en;
            rdata[CTRL_SAT_BIT] = r_sat_en;
         end
         ADDR_STATUS: begin
            rdata[STAT_BUSY_BIT]  = !w_idle;
            rdata[STAT_OVF_BIT]   = r_ovf;
            rdata[STAT_WRERR_BIT] = r_wr_err;
         end
         default: rdata = w_coeff_hit ? 16'(r_coeff[w_coeff_idx]) : 16'd0;
      endcase
   end

   assign src_ready_out = w_idle && r_en;
   assign dst_valid_out = (r_state == ST_OUT);
   assign dst_data_out  = r_dout;
   assign dst_ch_out    = r_dch;

endmodule

// File: tb/tb_pak_fir_tdm.sv
// Randomised and directed bench for pak_fir_tdm, checked against an
// arithmetic reference model of the per-channel FIR and status flags.
`timescale 1ns/1ps
module tb_pak_fir_tdm;
   import pak_fir_pkg::*;

   localparam int DW  = 16;
   localparam int CW  = 16;
   localparam int NT  = 8;
   localparam int NC  = 2;
   localparam int FW  = 14;
   localparam int CHW = 1;

   logic           clk;
   logic           arst_n;
   logic [5:0]     addr;
   logic           write_en;
   logic [15:0]    wdata;
   logic [15:0]    rdata;
   logic [DW-1:0]  src_data_in;
   logic [CHW-1:0] src_ch_in;
   logic           src_valid_in;
   logic           src_ready_out;
   logic [DW-1:0]  dst_data_out;
   logic [CHW-1:0] dst_ch_out;
   logic           dst_valid_out;
   logic           dst_ready_in;

   pak_fir_tdm #(
      .DATA_WIDTH (DW), .COEFF_WIDTH (CW), .N_TAPS (NT),
      .N_CH (NC), .FRAC_W (FW), .CH_W (CHW)
   ) dut (
      .clk (clk), .arst_n (arst_n), .addr (addr), .write_en (write_en),
      .wdata (wdata), .rdata (rdata),
      .src_data_in (src_data_in), .src_ch_in (src_ch_in),
      .src_valid_in (src_valid_in), .src_ready_out (src_ready_out),
      .dst_data_out (dst_data_out), .dst_ch_out (dst_ch_out),
      .dst_valid_out (dst_valid_out), .dst_ready_in (dst_ready_in)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int  n_vec = 0;
   int  n_err = 0;
   int  mh [NC][NT];
   int  mc [NT];
   bit  m_sat;
   bit  m_ovf;
   int  m_ch;
   time t_acc;

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic reg_wr(input logic [5:0] a, input logic [15:0] d);
      @(negedge clk);
      addr = a; wdata = d; write_en = 1'b1;
      @(posedge clk);
      #1 write_en = 1'b0;
   endtask

   task automatic reg_rd(input logic [5:0] a, output logic [15:0] d);
      @(negedge clk);
      addr = a;
      #1 d = rdata;
   endtask

   task automatic model_clear();
      for (int c = 0; c < NC; c++)
         for (int k = 0; k < NT; k++) mh[c][k] = 0;
   endtask

   task automatic set_ctrl(input bit en, input bit clr, input bit sat);
      reg_wr(ADDR_CTRL, {13'd0, sat, clr, en});
      m_sat = sat;
      if (clr) model_clear();
   endtask

   task automatic set_coef(input int k, input int v);
      reg_wr(ADDR_COEFF_BASE + 6'(k), 16'(v));
      mc[k] = v;
   endtask

   task automatic accept(input int ch, input int d);
      int n = 0;
      @(negedge clk);
      src_valid_in = 1'b1; src_data_in = 16'(d); src_ch_in = CHW'(ch);
      while (src_ready_out !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("ready_timeout", 0, 1);
      @(posedge clk);
      t_acc = $time;
      #1 src_valid_in = 1'b0;
      for (int k = NT - 1; k > 0; k--) mh[ch][k] = mh[ch][k-1];
      mh[ch][0] = d;
      m_ch = ch;
   endtask

   // Waits for the output, checks latency, value and channel against the model.
   task automatic collect(output int obs);
      int          n = 0;
      longint      acc;
      longint      r;
      int          exp;
      logic [15:0] lo;
      @(negedge clk);
      while (dst_valid_out !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("valid_timeout", 0, 1);
      chk("latency", longint'(($time - t_acc + 5) / 10), NT + 1);
      acc = 0;
      for (int k = 0; k < NT; k++) acc += longint'(mh[m_ch][k]) * longint'(mc[k]);
      r = (acc + (longint'(1) <<< (FW - 1))) >>> FW;
      if (r > 32767 || r < -32768) begin
         m_ovf = 1'b1;
         if (m_sat) exp = (r > 0) ? 32767 : -32768;
         else begin
            lo  = r[15:0];
            exp = int'($signed(lo));
         end
      end else begin
         exp = int'(r);
      end
      obs = int'($signed(dst_data_out));
      chk("dst_data", obs, exp);
      chk("dst_ch", longint'(dst_ch_out), m_ch);
   endtask

   task automatic send(input int ch, input int d, output int obs);
      accept(ch, d);
      collect(obs);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] rd;
      int          o;
      int          o1;
      int          v;
      int          lim;
      arst_n = 1'b0; addr = 6'd0; write_en = 1'b0; wdata = 16'd0;
      src_data_in = '0; src_ch_in = '0; src_valid_in = 1'b0; dst_ready_in = 1'b1;
      m_sat = 1'b0; m_ovf = 1'b0; m_ch = 0;
      model_clear();
      for (int k = 0; k < NT; k++) mc[k] = 0;
      repeat (3) @(negedge clk);
      arst_n = 1'b1;

      // Reset state
      #1;
      chk("rst_src_ready", src_ready_out, 0);
      chk("rst_dst_valid", dst_valid_out, 0);
      chk("rst_dst_data", dst_data_out, 0);
      reg_rd(ADDR_CTRL, rd);   chk("rst_ctrl", rd, 0);
      reg_rd(ADDR_STATUS, rd); chk("rst_status", rd, 0);
      reg_rd(6'h20, rd);       chk("rst_coef0", rd, 0);

      // Impulse response
      for (int k = 0; k < NT; k++) set_coef(k, 16384);
      reg_rd(6'h27, rd); chk("coef7_rd", rd, 16384);
      reg_rd(6'h28, rd); chk("unmapped_rd", rd, 0);
      set_ctrl(1'b1, 1'b0, 1'b1);
      reg_rd(ADDR_CTRL, rd); chk("ctrl_rd", rd, 5);
      for (int i = 0; i < 9; i++) begin
         send(0, (i == 0) ? 100 : 0, o);
         chk("impulse", o, (i < 8) ? 100 : 0);
      end

      // Channel isolation
      set_ctrl(1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 8; i++) begin
         send(0, (i == 0) ? 100 : 0, o);
         chk("iso_ch0", o, 100);
         send(1, 0, o1);
         chk("iso_ch1", o1, 0);
      end

      // Saturation then wrap on steady full-scale input
      set_ctrl(1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 8; i++) send(0, 32767, o);
      chk("sat_8th", o, 32767);
      reg_rd(ADDR_STATUS, rd); chk("sat_ovf", rd[1], 1);
      reg_wr(ADDR_STATUS, 16'h0002); m_ovf = 1'b0;
      reg_rd(ADDR_STATUS, rd); chk("ovf_w1c", rd[1], 0);
      set_ctrl(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) send(0, 32767, o);
      chk("wrap_8th", o, -8);
      reg_rd(ADDR_STATUS, rd); chk("wrap_ovf", rd[1], 1);
      reg_wr(ADDR_STATUS, 16'h0002); m_ovf = 1'b0;
      reg_rd(ADDR_STATUS, rd); chk("ovf_w1c2", rd[1], 0);

      // Rounding half toward +inf
      set_coef(0, 8192);
      for (int k = 1; k < NT; k++) set_coef(k, 0);
      set_ctrl(1'b1, 1'b1, 1'b1);
      send(0, 3, o);  chk("round_pos", o, 2);
      set_ctrl(1'b1, 1'b1, 1'b1);
      send(0, -3, o); chk("round_neg", o, -1);

      // Backpressure
      dst_ready_in = 1'b0;
      accept(1, 1000);
      collect(o);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_valid", dst_valid_out, 1);
         chk("bp_data", int'($signed(dst_data_out)), o);
         chk("bp_src_ready", src_ready_out, 0);
      end
      dst_ready_in = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("bp_release_ready", src_ready_out, 1);
      chk("bp_release_valid", dst_valid_out, 0);

      // Coefficient write while busy is dropped and flagged
      accept(0, 5);
      reg_rd(ADDR_STATUS, rd); chk("busy_mac", rd[0], 1);
      reg_wr(6'h23, 16'h1234);
      collect(o);
      @(posedge clk);
      #1;
      reg_rd(6'h23, rd); chk("busy_coef3", rd, mc[3]);
      reg_rd(ADDR_STATUS, rd); chk("busy_wrerr", rd[2], 1); chk("idle_busy", rd[0], 0);
      reg_wr(ADDR_STATUS, 16'h0004);
      reg_rd(ADDR_STATUS, rd); chk("wrerr_w1c", rd[2], 0);

      // EN dropped mid-operation: in-flight sample still completes
      accept(1, 40);
      reg_wr(ADDR_CTRL, 16'h0004);
      collect(o);
      @(posedge clk);
      @(negedge clk);
      chk("en_off_ready", src_ready_out, 0);
      set_ctrl(1'b1, 1'b0, 1'b1);

      // Randomised coefficients, data, channels and saturation mode
      for (int t = 0; t < 4; t++) begin
         lim = (t % 2 == 1) ? 32767 : 3000;
         for (int k = 0; k < NT; k++) set_coef(k, int'($urandom_range(0, 2 * lim)) - lim);
         v = int'($urandom_range(0, NT - 1));
         reg_rd(ADDR_COEFF_BASE + 6'(v), rd);
         chk("rand_coef_rd", int'($signed(rd)), mc[v]);
         set_ctrl(1'b1, 1'b1, 1'($urandom_range(0, 1)));
         for (int i = 0; i < 12; i++) begin
            send(int'($urandom_range(0, NC - 1)), int'($signed(16'($urandom))), o);
            reg_rd(ADDR_STATUS, rd);
            chk("rand_ovf", rd[1], m_ovf);
            if (m_ovf) begin
               reg_wr(ADDR_STATUS, 16'h0002);
               m_ovf = 1'b0;
            end
         end
      end

      // Reset mid-operation loses the pending output
      accept(0, 9);
      @(negedge clk);
      arst_n = 1'b0;
      addr = 6'h20;
      #1;
      chk("arst_valid", dst_valid_out, 0);
      chk("arst_ready", src_ready_out, 0);
      chk("arst_coef0", rdata, 0);
      @(negedge clk);
      arst_n = 1'b1;
      v = 0;
      for (int i = 0; i < NT + 4; i++) begin
         @(negedge clk);
         if (dst_valid_out === 1'b1) v++;
      end
      chk("arst_no_output", v, 0);
      reg_rd(ADDR_CTRL, rd);   chk("arst_ctrl", rd, 0);
      reg_rd(ADDR_STATUS, rd); chk("arst_status", rd, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
